// File: rtl/pe_sequencer.sv
// Single-PE job sequencer: weight load, input load, MAC, drain, optional activation, readout.
// Optional feature macro: PE_SEQ_WGT_REUSE_EN adds a reuse_wgt input that skips the weight-load phase.
module pe_sequencer #(
    parameter int DATA_W   = 32,
    parameter int N_MAX    = 16,
    parameter int MAC_LAT  = 5,
    parameter int ACT_LAT  = 14,
    localparam int LEN_W   = $clog2(N_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic              do_act,
`ifdef PE_SEQ_WGT_REUSE_EN
    input  logic              reuse_wgt,
`endif
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [2:0]        pe_ctrl,
    output logic              pe_output_ctrl,
    output logic              pe_enable_act,
    inout  wire  [DATA_W-1:0] pe_data,
    output logic [LEN_W-1:0]  beat_cnt
);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LD_WGT = 3'd1;
    localparam logic [2:0] OP_LD_IN  = 3'd2;
    localparam logic [2:0] OP_MAC    = 3'd3;
    localparam logic [2:0] OP_ACT    = 3'd4;

    localparam int WAIT_MAX0 = (ACT_LAT > MAC_LAT) ? ACT_LAT : MAC_LAT;
    localparam int WAIT_MAX  = (WAIT_MAX0 > 1) ? WAIT_MAX0 : 1;
    localparam int WAIT_W    = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_WGT,
        S_LD_IN,
        S_MAC,
        S_DRAIN,
        S_ACT,
        S_READ,
        S_HOLD
    } state_t;

    state_t             state, next_state;
    logic [LEN_W-1:0]   len_q;
    logic               act_q;
    logic [LEN_W-1:0]   beat_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
    logic               latch_job;
    logic               capture;
    logic               len_ok;
    logic               last_beat;
    logic               skip_wgt;

`ifdef PE_SEQ_WGT_REUSE_EN
    assign skip_wgt = reuse_wgt;
`else
    assign skip_wgt = 1'b0;
`endif

    assign len_ok    = (vec_len != '0) && (vec_len <= LEN_W'(N_MAX));
    assign last_beat = (beat_cnt == len_q - LEN_W'(1));
    assign busy      = (state != S_IDLE);

    // The bus is driven only while loading; in_ready doubles as the drive enable.
    assign pe_data = in_ready ? in_data : {DATA_W{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            wait_cnt <= '0;
            len_q    <= '0;
            act_q    <= 1'b0;
            out_data <= '0;
        end else begin
            state    <= next_state;
            beat_cnt <= beat_nxt;
            wait_cnt <= wait_nxt;
            if (latch_job) begin
                len_q <= vec_len;
                act_q <= do_act;
            end
            if (capture) begin
                out_data <= pe_data;
            end
        end
    end

    always_comb begin
        next_state     = state;
        beat_nxt       = beat_cnt;
        wait_nxt       = wait_cnt;
        latch_job      = 1'b0;
        capture        = 1'b0;
        in_ready       = 1'b0;
        pe_ctrl        = OP_NOP;
        pe_output_ctrl = 1'b0;
        pe_enable_act  = 1'b0;
        out_valid      = 1'b0;
        done           = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && len_ok) begin
                    latch_job  = 1'b1;
                    beat_nxt   = '0;
                    wait_nxt   = '0;
                    next_state = skip_wgt ? S_LD_IN : S_LD_WGT;
                end
            end
            S_LD_WGT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pe_ctrl = OP_LD_WGT;
                    if (last_beat) begin
                        beat_nxt   = '0;
                        next_state = S_LD_IN;
                    end else begin
                        beat_nxt = beat_cnt + LEN_W'(1);
                    end
                end
            end
            S_LD_IN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pe_ctrl = OP_LD_IN;
                    if (last_beat) begin
                        beat_nxt   = '0;
                        next_state = S_MAC;
                    end else begin
                        beat_nxt = beat_cnt + LEN_W'(1);
                    end
                end
            end
            S_MAC: begin
                // Beat 0 is the MAC the PE treats as accumulator clear.
                pe_ctrl = OP_MAC;
                if (last_beat) begin
                    beat_nxt   = '0;
                    wait_nxt   = '0;
                    next_state = S_DRAIN;
                end else begin
                    beat_nxt = beat_cnt + LEN_W'(1);
                end
            end
            S_DRAIN: begin
                if (wait_cnt == WAIT_W'(MAC_LAT - 1)) begin
                    wait_nxt   = '0;
                    next_state = act_q ? S_ACT : S_READ;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_ACT: begin
                if (wait_cnt == '0) begin
                    pe_ctrl       = OP_ACT;
                    pe_enable_act = 1'b1;
                end
                if (wait_cnt == WAIT_W'(ACT_LAT)) begin
                    wait_nxt   = '0;
                    next_state = S_READ;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_READ: begin
                // First cycle is bus turnaround; the PE value is sampled at the end of the second.
                pe_output_ctrl = 1'b1;
                if (wait_cnt == WAIT_W'(1)) begin
                    capture    = 1'b1;
                    wait_nxt   = '0;
                    next_state = S_HOLD;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    done       = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a same-cycle result handshake.
        if (abort && (state != S_IDLE)) begin
            next_state     = S_IDLE;
            beat_nxt       = '0;
            wait_nxt       = '0;
            capture        = 1'b0;
            in_ready       = 1'b0;
            pe_ctrl        = OP_NOP;
            pe_output_ctrl = 1'b0;
            pe_enable_act  = 1'b0;
            out_valid      = 1'b0;
            done           = 1'b0;
        end
    end

endmodule

// File: tb/tb_pe_sequencer.sv
// Bench for pe_sequencer: randomized jobs, a behavioural PE on the shared bus, and a spec-derived timeline.
module tb_pe_sequencer;

    localparam int DATA_W  = 32;
    localparam int N_MAX   = 16;
    localparam int MAC_LAT = 5;
    localparam int ACT_LAT = 14;
    localparam int LEN_W   = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  vec_len;
    logic              do_act;
    logic              abort;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic [2:0]        pe_ctrl;
    logic              pe_output_ctrl;
    logic              pe_enable_act;
    wire  [DATA_W-1:0] pe_data;
    logic [LEN_W-1:0]  beat_cnt;

    int vectors = 0;
    int miscompares = 0;
    int cyc;
    logic [DATA_W-1:0] words [2*N_MAX];

    always #5 clk = ~clk;

    pe_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .do_act(do_act),
        .abort(abort), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .done(done), .pe_ctrl(pe_ctrl), .pe_output_ctrl(pe_output_ctrl),
        .pe_enable_act(pe_enable_act), .pe_data(pe_data), .beat_cnt(beat_cnt)
    );

    // Behavioural PE: stores operands, integer dot product, activation modelled as bitwise invert.
    logic [DATA_W-1:0] pe_w [N_MAX];
    logic [DATA_W-1:0] pe_x [N_MAX];
    logic [DATA_W-1:0] pe_acc = '0;
    int pe_wi = 0, pe_xi = 0, pe_mi = 0;
    logic [2:0] pe_last = 3'd0;

    assign pe_data = pe_output_ctrl ? pe_acc : {DATA_W{1'bz}};

    always @(posedge clk) begin
        case (pe_ctrl)
            3'd1: begin
                if (pe_last != 3'd1) pe_wi = 0;
                if (pe_wi < N_MAX) pe_w[pe_wi] = pe_data;
                pe_wi++;
                pe_last = 3'd1;
            end
            3'd2: begin
                if (pe_last != 3'd2) pe_xi = 0;
                if (pe_xi < N_MAX) pe_x[pe_xi] = pe_data;
                pe_xi++;
                pe_last = 3'd2;
            end
            3'd3: begin
                if (pe_last != 3'd3) begin
                    pe_acc = '0;
                    pe_mi  = 0;
                end
                if (pe_mi < N_MAX) pe_acc = pe_acc + pe_w[pe_mi] * pe_x[pe_mi];
                pe_mi++;
                pe_last = 3'd3;
            end
            3'd4: begin
                if (pe_enable_act) pe_acc = ~pe_acc;
                pe_last = 3'd4;
            end
            default: ;
        endcase
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] expected_result(input int n, input bit act);
        logic [DATA_W-1:0] acc = '0;
        for (int i = 0; i < n; i++) acc = acc + words[i] * words[n + i];
        return act ? ~acc : acc;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_ready"}, in_ready, 0);
        check_output({tag, "_ctrl"}, pe_ctrl, 0);
        check_output({tag, "_oc"}, pe_output_ctrl, 0);
        check_output({tag, "_act"}, pe_enable_act, 0);
        check_output({tag, "_ovalid"}, out_valid, 0);
        check_output({tag, "_done"}, done, 0);
        check_output({tag, "_beat"}, beat_cnt, 0);
    endtask

    task automatic apply_stimulus(input int n, input bit act, input bit with_abort);
        @(negedge clk);
        for (int i = 0; i < 2 * n; i++) words[i] = $urandom;
        vec_len  = LEN_W'(n);
        do_act   = act;
        start    = 1'b1;
        abort    = with_abort;
        in_valid = 1'b0;
        in_data  = $urandom;
        cyc      = 0;
        #1;
        check_output("start_busy", busy, 0);
        @(negedge clk);
        cyc   = 1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic load_words(input int n, input bit gap, input int max_beats, output int load_cycles);
        int k = 0;
        int t = 0;
        bit v;
        while (k < max_beats) begin
            v        = gap ? (t % 2 == 0) : 1'b1;
            in_valid = v;
            in_data  = v ? words[k] : $urandom;
            #1;
            check_output("ld_ready", in_ready, 1);
            check_output("ld_busy", busy, 1);
            check_output("ld_ctrl", pe_ctrl, v ? ((k < n) ? 1 : 2) : 0);
            check_output("ld_beat", beat_cnt, k % n);
            check_output("ld_oc", pe_output_ctrl, 0);
            if (v) k++;
            t++;
            @(negedge clk);
            cyc++;
        end
        in_valid    = 1'b0;
        load_cycles = t;
    endtask

    task automatic finish_job(input int n, input bit act, input int hold_wait, input bit abort_hold,
                              input int load_cycles);
        logic [DATA_W-1:0] exp_res = expected_result(n, act);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            #1;
            check_output("mac_ctrl", pe_ctrl, 3);
            check_output("mac_beat", beat_cnt, i);
            check_output("mac_ready", in_ready, 0);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < MAC_LAT; i++) begin
            #1;
            check_output("drain_ctrl", pe_ctrl, 0);
            check_output("drain_busy", busy, 1);
            check_output("drain_oc", pe_output_ctrl, 0);
            check_output("drain_act", pe_enable_act, 0);
            @(negedge clk);
            cyc++;
        end
        if (act) begin
            for (int i = 0; i <= ACT_LAT; i++) begin
                #1;
                check_output("act_ctrl", pe_ctrl, (i == 0) ? 4 : 0);
                check_output("act_en", pe_enable_act, (i == 0) ? 1 : 0);
                @(negedge clk);
                cyc++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            check_output("read_oc", pe_output_ctrl, 1);
            check_output("read_ctrl", pe_ctrl, 0);
            check_output("read_ovalid", out_valid, 0);
            @(negedge clk);
            cyc++;
        end
        check_output("latency", cyc, 1 + load_cycles + n + MAC_LAT + (act ? 1 + ACT_LAT : 0) + 2);
        for (int h = 0; h < hold_wait; h++) begin
            out_ready = 1'b0;
            start     = 1'($urandom_range(0, 1));
            vec_len   = LEN_W'($urandom_range(1, N_MAX));
            #1;
            check_output("hold_ovalid", out_valid, 1);
            check_output("hold_data", out_data, exp_res);
            check_output("hold_done", done, 0);
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        abort     = abort_hold;
        #1;
        if (abort_hold) begin
            check_output("abort_hs_done", done, 0);
            check_output("abort_hs_ovalid", out_valid, 0);
        end else begin
            check_output("hs_ovalid", out_valid, 1);
            check_output("hs_data", out_data, exp_res);
            check_output("hs_done", done, 1);
        end
        @(negedge clk);
        cyc++;
        out_ready = 1'b0;
        abort     = 1'b0;
        #1;
        check_idle_outputs("post_job");
    endtask

    task automatic run_job(input int n, input bit act, input bit gap, input int hold_wait, input bit abort_hold);
        int lc;
        apply_stimulus(n, act, 1'b0);
        load_words(n, gap, 2 * n, lc);
        check_output("load_beats", gap ? lc : 2 * n, gap ? 4 * n - 1 : lc);
        finish_job(n, act, hold_wait, abort_hold, lc);
    endtask

    initial begin
        int lc;
        rst_n = 1'b0; start = 1'b0; vec_len = '0; do_act = 1'b0; abort = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0; cyc = 0;
        #3;
        check_idle_outputs("reset");
        check_output("reset_odata", out_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic jobs");
        run_job(4, 1'b0, 1'b0, 0, 1'b0);
        run_job(4, 1'b1, 1'b0, 0, 1'b0);
        run_job(4, 1'b0, 1'b1, 10, 1'b0);

        $display("[TB] illegal lengths");
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            vec_len = (j == 0) ? 5'd0 : ((j == 1) ? 5'd17 : 5'd31);
            start   = 1'b1;
            #1;
            check_output("badlen_busy0", busy, 0);
            @(negedge clk);
            start = 1'b0;
            #1;
            check_idle_outputs("badlen");
        end

        $display("[TB] max length");
        run_job(16, 1'($urandom_range(0, 1)), 1'b0, 3, 1'b0);

        $display("[TB] abort during MAC");
        apply_stimulus(6, 1'b0, 1'b0);
        load_words(6, 1'b0, 12, lc);
        for (int i = 0; i < 2; i++) begin
            #1;
            check_output("pre_abort_ctrl", pe_ctrl, 3);
            @(negedge clk);
            cyc++;
        end
        abort = 1'b1;
        #1;
        check_output("abort_ctrl", pe_ctrl, 0);
        check_output("abort_busy", busy, 1);
        @(negedge clk);
        abort = 1'b0;
        #1;
        check_idle_outputs("after_abort");

        $display("[TB] async reset during input load");
        apply_stimulus(5, 1'b1, 1'b0);
        load_words(5, 1'b0, 7, lc);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        check_output("midreset_odata", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(3, 1'b1, 1'b0, 2, 1'b0);

        $display("[TB] abort against handshake, start with abort in idle");
        run_job(5, 1'b0, 1'b0, 2, 1'b1);
        apply_stimulus(7, 1'b1, 1'b1);
        load_words(7, 1'b0, 14, lc);
        finish_job(7, 1'b1, 1, 1'b0, lc);

        $display("[TB] random jobs");
        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(1, N_MAX), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
